cache_controller: RTL
=====================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter SRAM_LINE_W, default 64, width in bits of one SRAM line transfer (two 32-bit words).
REQ-002 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-003 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 R_EN  input  1  MEM-stage read request, held stable while ready=0.
REQ-007 W_EN  input  1  MEM-stage write request, held stable while ready=0.
REQ-008 address  input  32  byte address: offset [2:0], word select [2], index [8:3], tag [18:9].
REQ-009 data_in  input  32  write data.
REQ-010 data_out  output  32  read data to MEM stage.
REQ-011 ready  output  1  1 = request complete or no request; 0 = freeze pipeline.
REQ-012 cache_hit  input  1  lookup hit from cache storage for current address (combinational).
REQ-013 cache_rdata  input  32  hit word from cache storage.
REQ-014 cache_fill_en  output  1  one-cycle pulse: write cache_fill_line into LRU way at index, set valid, update LRU.
REQ-015 cache_fill_line  output  64  line data for the fill.
REQ-016 cache_inval_en  output  1  one-cycle pulse: clear valid of the hitting way at index.
REQ-017 sram_r_en  output  1  SRAM line read request.
REQ-018 sram_w_en  output  1  SRAM word write request.
REQ-019 sram_address  output  32  SRAM address.
REQ-020 sram_wdata  output  32  SRAM write data (= data_in).
REQ-021 sram_rdata  input  64  SRAM line, word 0 in [31:0], word 1 in [63:32].
REQ-022 sram_ready  input  1  SRAM completes the pending access this cycle.
REQ-023 hit_count, miss_count  output  CNT_W each  read hit / read miss counters.

Function
REQ-024 SHALL implement FSM states IDLE, READ_MISS, WRITE.
REQ-025 In IDLE with W_EN=1: SHALL pulse cache_inval_en iff cache_hit, assert sram_w_en, ready=0, go to WRITE; W_EN has priority over R_EN.
REQ-026 In IDLE with R_EN=1, W_EN=0, cache_hit=1: SHALL drive data_out=cache_rdata and ready=1 in the same cycle, stay IDLE, increment hit_count.
REQ-027 In IDLE with R_EN=1, W_EN=0, cache_hit=0: SHALL assert sram_r_en, ready=0, go to READ_MISS, increment miss_count.
REQ-028 In IDLE with no request: ready=1, all SRAM and cache command outputs 0.
REQ-029 sram_address SHALL be {address[31:3],3'b000} for reads and address for writes.
REQ-030 In READ_MISS: sram_r_en SHALL stay 1 until sram_ready; in the sram_ready cycle, cache_fill_en=1, cache_fill_line=sram_rdata, data_out=sram_rdata word selected by address[2], ready=1, next state IDLE.
REQ-031 In WRITE: sram_w_en SHALL stay 1 until sram_ready; in that cycle ready=1, next state IDLE; cache is never allocated on write.
REQ-032 sram_ready SHALL be ignored in IDLE.
REQ-033 Counters SHALL saturate at all-ones, never wrap.
REQ-034 cache_fill_en and cache_inval_en SHALL never both be 1; each is at most one cycle per request.
REQ-035 data_out SHALL be 0 when ready=0 or no read completes.

Reset
REQ-036 rst=1 SHALL immediately force IDLE, ready=1, data_out=0, all sram_*/cache_* command outputs 0, counters 0, including mid-miss or mid-write; a pending SRAM access is abandoned.

Verification
REQ-037 Read hit: cache_hit=1, cache_rdata=0xDEADBEEF, R_EN=1 -> ready=1 and data_out=0xDEADBEEF the same cycle, hit_count=1.
REQ-038 Read miss at address 0x0000_0404, sram_ready after 3 cycles with sram_rdata=0x11111111_22222222 -> sram_address=0x0000_0400, ready=0 for 3 cycles, then data_out=0x11111111, cache_fill_en one cycle, miss_count=1.
REQ-039 Write hit at 0x0000_0010, data_in=0xA5A5A5A5, sram_ready after 2 cycles -> cache_inval_en one cycle, sram_wdata=0xA5A5A5A5, sram_address=0x0000_0010, ready=1 in completion cycle.
REQ-040 R_EN=1 and W_EN=1 together -> WRITE path taken, no sram_r_en, miss_count unchanged.
REQ-041 rst asserted in READ_MISS before sram_ready -> same cycle sram_r_en=0, ready=1, counters 0; next read starts from IDLE.
REQ-042 Force hit_count to all-ones, issue read hit -> hit_count stays 0xFFFF.

Source files
------------

// File: rtl/cache_controller.sv
// Blocking cache controller sitting between the MEM stage, the cache storage and a line-wide SRAM.
// Reads allocate on miss; writes go straight through to SRAM and invalidate a hitting line.
module cache_controller #(
    parameter int SRAM_LINE_W = 64,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   R_EN,
    input  logic                   W_EN,
    input  logic [31:0]            address,
    input  logic [31:0]            data_in,
    output logic [31:0]            data_out,
    output logic                   ready,
    input  logic                   cache_hit,
    input  logic [31:0]            cache_rdata,
    output logic                   cache_fill_en,
    output logic [SRAM_LINE_W-1:0] cache_fill_line,
    output logic                   cache_inval_en,
    output logic                   sram_r_en,
    output logic                   sram_w_en,
    output logic [31:0]            sram_address,
    output logic [31:0]            sram_wdata,
    input  logic [SRAM_LINE_W-1:0] sram_rdata,
    input  logic                   sram_ready,
    output logic [CNT_W-1:0]       hit_count,
    output logic [CNT_W-1:0]       miss_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_t;

    state_t      state, state_next;
    logic        hit_inc, miss_inc;
    logic [31:0] line_address;

    assign line_address = {address[31:3], 3'b000};
    assign sram_wdata   = data_in;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Outputs are gated by rst so an assertion mid-transaction drops every command immediately.
    always_comb begin
        // NOTE: every output gets a default first, otherwise partial assignment infers latches.
        state_next      = state;
        ready           = 1'b1;
        data_out        = '0;
        cache_fill_en   = 1'b0;
        cache_fill_line = '0;
        cache_inval_en  = 1'b0;
        sram_r_en       = 1'b0;
        sram_w_en       = 1'b0;
        sram_address    = '0;
        hit_inc         = 1'b0;
        miss_inc        = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (W_EN) begin
                        cache_inval_en = cache_hit;
                        sram_w_en      = 1'b1;
                        sram_address   = address;
                        ready          = 1'b0;
                        state_next     = WRITE;
                    end else if (R_EN) begin
                        if (cache_hit) begin
                            data_out = cache_rdata;
                            hit_inc  = 1'b1;
                        end else begin
                            sram_r_en    = 1'b1;
                            sram_address = line_address;
                            ready        = 1'b0;
                            miss_inc     = 1'b1;
                            state_next   = READ_MISS;
                        end
                    end
                end
                READ_MISS: begin
                    sram_r_en    = 1'b1;
                    sram_address = line_address;
                    if (sram_ready) begin
                        cache_fill_en   = 1'b1;
                        cache_fill_line = sram_rdata;
                        data_out        = address[2] ? sram_rdata[32 +: 32] : sram_rdata[0 +: 32];
                        state_next      = IDLE;
                    end else begin
                        ready = 1'b0;
                    end
                end
                WRITE: begin
                    sram_w_en    = 1'b1;
                    sram_address = address;
                    if (sram_ready) state_next = IDLE;
                    else            ready      = 1'b0;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc && (hit_count != '1))   hit_count  <= hit_count + 1'b1;
            if (miss_inc && (miss_count != '1)) miss_count <= miss_count + 1'b1;
        end
    end

endmodule
